// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between
//               two requesters. The winning request drives the ALU, the
//               result is registered and returned on a valid/ready response
//               channel tagged with the requester id. One op in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;      // preferred requester on contention
  logic             grant_any;   // a transfer happens on the next edge
  logic             winner;      // id of the granted requester
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Grant selection: only possible in IDLE; ties go to rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    winner    = 1'b0;
    if (state == IDLE) begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        winner = rr_ptr;
      end else begin
        winner = req1_valid;
      end
    end
  end

  // Payload mux from the winning requester.
  always_comb begin
    win_op = req0_op;
    win_a  = req0_a;
    win_b  = req0_b;
    if (winner) begin
      win_op = req1_op;
      win_a  = req1_a;
      win_b  = req1_b;
    end
  end

  // ALU drive and requester handshakes; everything idles at zero without a grant.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 3'b000;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    if (grant_any) begin
      alu_a       = win_a;
      alu_b       = win_b;
      alu_control = win_op;
      req0_ready  = ~winner;
      req1_ready  = winner;
    end
  end

  // Next-state logic: a grant moves to RESP, a consumed response returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin pointer: the loser of a transfer is preferred next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant_any) begin
      rr_ptr <= ~winner;
    end
  end

  // Response registers: captured on a transfer, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (grant_any) begin
      resp_id     <= winner;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_err    <= win_op[2];
    end
  end

  // The response is valid exactly while the FSM waits for the consumer.
  assign resp_valid = (state == RESP);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Directed scenarios plus
//               randomized traffic compared against a transaction-level model
//               (queue of expected responses and a preferred-requester bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op, alu_control;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;
  logic             resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [WIDTH-1:0] resp_result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } rsp_t;

  rsp_t q[$];          // expected responses (at most one outstanding)
  logic pref = 1'b0;   // requester favoured on a tie
  logic acc0, acc1;    // requester was accepted in the last cycle

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared ALU.
  always_comb begin
    alu_result = ref_alu(alu_control, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Arbitration rule: -1 none, else the winning requester.
  function automatic int pick(input logic v0, input logic v1, input logic p);
    if (v0 && v1) return int'(p);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock: inputs were set after a falling edge; check, advance model, clock.
  task automatic cycle();
    int               w;
    logic [WIDTH-1:0] ea, eb;
    logic [2:0]       eop;
    rsp_t             r;
    #1;
    w   = (q.size() == 0) ? pick(req0_valid, req1_valid, pref) : -1;
    ea  = (w == 0) ? req0_a  : (w == 1) ? req1_a  : '0;
    eb  = (w == 0) ? req0_b  : (w == 1) ? req1_b  : '0;
    eop = (w == 0) ? req0_op : (w == 1) ? req1_op : 3'b000;
    if (!rst) begin
      check_eq("req0_ready", req0_ready, w == 0);
      check_eq("req1_ready", req1_ready, w == 1);
      check_eq("alu_a", alu_a, ea);
      check_eq("alu_b", alu_b, eb);
      check_eq("alu_control", alu_control, eop);
    end
    check_eq("resp_valid", resp_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("resp_id", resp_id, q[0].id);
      check_eq("resp_result", resp_result, q[0].res);
      check_eq("resp_zero", resp_zero, q[0].zero);
      check_eq("resp_err", resp_err, q[0].err);
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      q.delete();
      pref = 1'b0;
    end else if (q.size() != 0) begin
      if (resp_ready) void'(q.pop_front());
    end else if (w >= 0) begin
      r.id   = (w == 1);
      r.res  = ref_alu(eop, ea, eb);
      r.zero = (r.res == '0);
      r.err  = eop[2];
      q.push_back(r);
      pref = (w == 0);
      acc0 = (w == 0);
      acc1 = (w == 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [2:0] rand_op();
    return ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                       : 3'($urandom_range(0, 3));
  endfunction

  // New payload only when the previous one was accepted or none was pending.
  task automatic rand_inputs();
    if (!req0_valid || acc0) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_op = rand_op(); req0_a = rand64(); req0_b = rand64();
      if ($urandom_range(0, 5) == 0) req0_b = req0_a;
    end
    if (!req1_valid || acc1) begin
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_op = rand_op(); req1_a = rand64(); req1_b = rand64();
      if ($urandom_range(0, 5) == 0) req1_b = req1_a;
    end
    resp_ready = ($urandom_range(0, 2) != 0);
    rst        = ($urandom_range(0, 199) == 0);
  endtask

  logic [WIDTH-1:0] held;

  initial begin
    // Power-up reset: DUT state is unknown before it, so no model checks yet.
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_valid", resp_valid, 0);
    check_eq("rst_id", resp_id, 0);
    check_eq("rst_result", resp_result, 0);
    check_eq("rst_zero", resp_zero, 0);
    check_eq("rst_err", resp_err, 0);
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    @(negedge clk);

    // Single add.
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 64'd10; req0_b = 64'd5;
    cycle();
    req0_valid = 1'b0;
    check_eq("add_valid", resp_valid, 1);
    check_eq("add_id", resp_id, 0);
    check_eq("add_result", resp_result, 64'd15);
    check_eq("add_zero", resp_zero, 0);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;

    // Subtract to zero from requester 1.
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 64'd20; req1_b = 64'd20;
    cycle();
    req1_valid = 1'b0;
    check_eq("sub_id", resp_id, 1);
    check_eq("sub_result", resp_result, 0);
    check_eq("sub_zero", resp_zero, 1);
    check_eq("sub_err", resp_err, 0);
    resp_ready = 1'b1;
    cycle();

    // Contention from reset: grants alternate 0,1,0,1 every two cycles.
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b011;
    req0_a = 64'hF0F0_F0F0_F0F0_F0F0; req0_b = 64'h0F0F_0F0F_0F0F_0F0F;
    req1_valid = 1'b1; req1_op = 3'b011;
    req1_a = req0_a; req1_b = req0_b;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("cont_ready0", req0_ready, (i % 4) == 0);
      check_eq("cont_ready1", req1_ready, (i % 4) == 2);
      if (i % 2 == 1) begin
        check_eq("cont_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("cont_id", resp_id, (i % 4) == 3);
      end
      cycle();
    end
    idle_inputs();
    cycle();

    // Backpressure: response held for 5 cycles with requests pending.
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 64'd1234; req0_b = 64'd4321;
    cycle();
    held = resp_result;
    check_eq("bp_capture", held, 64'd5555);
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 64'hFF; req1_b = 64'h0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_stable", resp_result, held);
      check_eq("bp_ready", {req0_ready, req1_ready}, 0);
      cycle();
    end
    resp_ready = 1'b1;
    cycle();
    #1;
    check_eq("bp_idle_valid", resp_valid, 0);
    check_eq("bp_idle_grant", req0_ready | req1_ready, 1);
    resp_ready = 1'b1;
    cycle();
    idle_inputs();
    resp_ready = 1'b1;
    cycle();
    cycle();

    // Illegal op goes through with a zero result and the error flag.
    idle_inputs();
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 64'd7; req0_b = 64'd3;
    cycle();
    req0_valid = 1'b0;
    check_eq("ill_result", resp_result, 0);
    check_eq("ill_err", resp_err, 1);
    check_eq("ill_zero", resp_zero, 1);

    // Reset while a response is pending, preference set towards requester 1.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("mid_rst_valid", resp_valid, 0);
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 64'd2; req0_b = 64'd3;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 64'd4; req1_b = 64'd5;
    #1;
    check_eq("mid_rst_grant0", req0_ready, 1);
    check_eq("mid_rst_grant1", req1_ready, 0);
    cycle();
    check_eq("mid_rst_result", resp_result, 64'd5);

    // Randomized traffic against the model.
    resp_ready = 1'b1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
